// File: rtl/logic_gate_unit_pkg.sv
// Shared types for logic_gate_unit: op encoding and widths.
package logic_gate_unit_pkg;

  localparam int unsigned GATE_OP_W = 2;

  // Result selector carried alongside the operands.
  typedef enum logic [GATE_OP_W-1:0] {
    GATE_AND   = 2'd0,
    GATE_NAND  = 2'd1,
    GATE_NOT_A = 2'd2,
    GATE_NOT_B = 2'd3
  } gate_op_e;

endpackage : logic_gate_unit_pkg

// File: rtl/logic_gate_unit_gate_cell.sv
// gate_cell: single-bit AND/NAND/NOT_A/NOT_B with a 4:1 result select.
// Purely combinational; all registering happens in logic_gate_unit.
module gate_cell
  import logic_gate_unit_pkg::*;
(
  input  logic     i_a,
  input  logic     i_b,
  input  gate_op_e i_op,
  output logic     o_and_c,
  output logic     o_nand_c,
  output logic     o_not_a_c,
  output logic     o_not_b_c,
  output logic     o_sel_c
);

  logic w_and;

  assign w_and     = i_a & i_b;
  assign o_and_c   = w_and;
  assign o_nand_c  = ~w_and;
  assign o_not_a_c = ~i_a;
  assign o_not_b_c = ~i_b;

  // Pick the result named by the op sampled with this bit's operands.
  always_comb begin
    o_sel_c = w_and;
    case (i_op)
      GATE_AND:   o_sel_c = w_and;
      GATE_NAND:  o_sel_c = ~w_and;
      GATE_NOT_A: o_sel_c = ~i_a;
      GATE_NOT_B: o_sel_c = ~i_b;
      default:    o_sel_c = w_and;
    endcase
  end

endmodule : gate_cell

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise AND/NAND/NOT_A/NOT_B on WIDTH-bit
// operands with a selected-result bus, one-cycle latency.
// Optional zero/all-ones flags on the selected result: LOGIC_GATE_UNIT_FLAGS_EN.
module logic_gate_unit
  import logic_gate_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  gate_op_e         op,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_q,
  output logic [WIDTH-1:0] nand_q,
  output logic [WIDTH-1:0] not_a_q,
  output logic [WIDTH-1:0] not_b_q,
  output logic [WIDTH-1:0] sel_q
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
  ,
  output logic             zero_q,
  output logic             ones_q
`endif
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_not_a;
  logic [WIDTH-1:0] w_not_b;
  logic [WIDTH-1:0] w_sel;

  logic             r_valid;
  logic [WIDTH-1:0] r_and;
  logic [WIDTH-1:0] r_nand;
  logic [WIDTH-1:0] r_not_a;
  logic [WIDTH-1:0] r_not_b;
  logic [WIDTH-1:0] r_sel;

  // One independent gate cell per bit; no carries between bits.
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    gate_cell u_cell (
      .i_a       (a[g]),
      .i_b       (b[g]),
      .i_op      (op),
      .o_and_c   (w_and[g]),
      .o_nand_c  (w_nand[g]),
      .o_not_a_c (w_not_a[g]),
      .o_not_b_c (w_not_b[g]),
      .o_sel_c   (w_sel[g])
    );
  end

  // Result registers load only on valid input; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_and   <= '0;
      r_nand  <= '0;
      r_not_a <= '0;
      r_not_b <= '0;
      r_sel   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_and   <= w_and;
        r_nand  <= w_nand;
        r_not_a <= w_not_a;
        r_not_b <= w_not_b;
        r_sel   <= w_sel;
      end
    end
  end

  assign out_valid = r_valid;
  assign and_q     = r_and;
  assign nand_q    = r_nand;
  assign not_a_q   = r_not_a;
  assign not_b_q   = r_not_b;
  assign sel_q     = r_sel;

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
  logic w_zero;
  logic w_ones;
  logic r_zero;
  logic r_ones;

  assign w_zero = ~|w_sel;
  assign w_ones = &w_sel;

  // Flags track sel_q: same load enable and reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ones <= 1'b0;
    end else if (in_valid) begin
      r_zero <= w_zero;
      r_ones <= w_ones;
    end
  end

  assign zero_q = r_zero;
  assign ones_q = r_ones;
`endif

endmodule : logic_gate_unit

// File: tb/tb_logic_gate_unit.sv
// Table-driven bench for logic_gate_unit at WIDTH=4: each row drives one
// cycle and queues the outputs expected after the next rising edge.
module tb_logic_gate_unit;
  import logic_gate_unit_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned NVEC = 15;

  typedef struct {
    logic     rst_n;
    logic     valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    gate_op_e op;
    logic     e_valid;
    logic [W-1:0] e_and;
    logic [W-1:0] e_nand;
    logic [W-1:0] e_not_a;
    logic [W-1:0] e_not_b;
    logic [W-1:0] e_sel;
    logic     e_zero;
    logic     e_ones;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  gate_op_e     op;
  logic         out_valid;
  logic [W-1:0] and_q;
  logic [W-1:0] nand_q;
  logic [W-1:0] not_a_q;
  logic [W-1:0] not_b_q;
  logic [W-1:0] sel_q;
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
  logic         zero_q;
  logic         ones_q;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NVEC];
  vec_t sb_q[$];

  logic_gate_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .and_q     (and_q),
    .nand_q    (nand_q),
    .not_a_q   (not_a_q),
    .not_b_q   (not_b_q),
    .sel_q     (sel_q)
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    ,
    .zero_q    (zero_q),
    .ones_q    (ones_q)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] ia,
                              input logic [W-1:0] ib, input gate_op_e iop,
                              input logic ev, input logic [W-1:0] ea, input logic [W-1:0] en,
                              input logic [W-1:0] ena, input logic [W-1:0] enb,
                              input logic [W-1:0] es, input logic ez, input logic eo);
    vec_t t;
    t.rst_n = r;   t.valid = v;    t.a = ia;        t.b = ib;        t.op = iop;
    t.e_valid = ev; t.e_and = ea;  t.e_nand = en;   t.e_not_a = ena; t.e_not_b = enb;
    t.e_sel = es;  t.e_zero = ez;  t.e_ones = eo;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare against current DUT outputs.
  task automatic compare_head(input int idx);
    vec_t e;
    e = sb_q.pop_front();
    check("out_valid", idx, W'(out_valid), W'(e.e_valid));
    check("and_q",     idx, and_q,   e.e_and);
    check("nand_q",    idx, nand_q,  e.e_nand);
    check("not_a_q",   idx, not_a_q, e.e_not_a);
    check("not_b_q",   idx, not_b_q, e.e_not_b);
    check("sel_q",     idx, sel_q,   e.e_sel);
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    check("zero_q",    idx, W'(zero_q), W'(e.e_zero));
    check("ones_q",    idx, W'(ones_q), W'(e.e_ones));
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = GATE_AND;

    // Reset held two cycles with valid operands present: reset wins.
    vecs[0]  = mk(0, 1, 4'hF, 4'hF, GATE_AND,   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    vecs[1]  = mk(0, 1, 4'hF, 4'hF, GATE_AND,   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    // Truth table a=0011 b=0101, then op sweep back-to-back.
    vecs[2]  = mk(1, 1, 4'h3, 4'h5, GATE_AND,   1, 4'h1, 4'hE, 4'hC, 4'hA, 4'h1, 0, 0);
    vecs[3]  = mk(1, 1, 4'h3, 4'h5, GATE_NAND,  1, 4'h1, 4'hE, 4'hC, 4'hA, 4'hE, 0, 0);
    vecs[4]  = mk(1, 1, 4'h3, 4'h5, GATE_NOT_A, 1, 4'h1, 4'hE, 4'hC, 4'hA, 4'hC, 0, 0);
    vecs[5]  = mk(1, 1, 4'h3, 4'h5, GATE_NOT_B, 1, 4'h1, 4'hE, 4'hC, 4'hA, 4'hA, 0, 0);
    // Hold: operands change but valid is low.
    vecs[6]  = mk(1, 0, 4'hA, 4'h6, GATE_AND,   0, 4'h1, 4'hE, 4'hC, 4'hA, 4'hA, 0, 0);
    vecs[7]  = mk(1, 1, 4'hA, 4'h6, GATE_AND,   1, 4'h2, 4'hD, 4'h5, 4'h9, 4'h2, 0, 0);
    vecs[8]  = mk(1, 1, 4'hF, 4'hF, GATE_NAND,  1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
    // Flag corners: all-zero and all-ones selected results.
    vecs[9]  = mk(1, 1, 4'h0, 4'h0, GATE_AND,   1, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1, 0);
    vecs[10] = mk(1, 1, 4'h0, 4'h0, GATE_NAND,  1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 1);
    vecs[11] = mk(1, 1, 4'hC, 4'hA, GATE_NOT_B, 1, 4'h8, 4'h7, 4'h3, 4'h5, 4'h5, 0, 0);
    // Mid-stream reset: the op offered at the reset edge is lost.
    vecs[12] = mk(0, 1, 4'h3, 4'h5, GATE_AND,   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    vecs[13] = mk(1, 0, 4'hF, 4'h0, GATE_AND,   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    vecs[14] = mk(1, 1, 4'h3, 4'h5, GATE_NOT_A, 1, 4'h1, 4'hE, 4'hC, 4'hA, 4'hC, 0, 0);

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) compare_head(i - 1);
      rst_n    = vecs[i].rst_n;
      in_valid = vecs[i].valid;
      a        = vecs[i].a;
      b        = vecs[i].b;
      op       = vecs[i].op;
      sb_q.push_back(vecs[i]);
    end

    @(negedge clk);
    in_valid = 1'b0;
    if (sb_q.size() != 0) compare_head(int'(NVEC) - 1);

    // Idle cycle after the last op: results hold, valid drops.
    @(negedge clk);
    check("idle out_valid", int'(NVEC), W'(out_valid), W'(1'b0));
    check("idle sel_q",     int'(NVEC), sel_q, 4'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so the bench cannot hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule : tb_logic_gate_unit
